sw_irq_sb_ctrl: RTL and testbench

SW_IRQ_SB_CTRL -- requirements
Module: sw_irq_sb_ctrl

---
 rtl/sw_ctrl_pkg.sv | 29 ++
 rtl/sw_debounce.sv | 58 +++++
 rtl/sw_irq_sb_ctrl.sv | 98 +++++++++
 tb/tb_sw_irq_sb_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sw_ctrl_pkg.sv
// Shared constants for the switch interrupt controller: register offsets
// and a decoder that maps a byte offset onto a register select.
package sw_ctrl_pkg;

  localparam logic [7:0] OFF_VALUE = 8'h00;
  localparam logic [7:0] OFF_MASK  = 8'h04;
  localparam logic [7:0] OFF_PEND  = 8'h08;
  localparam logic [7:0] OFF_CTRL  = 8'h0C;

  typedef enum logic [2:0] {
    REG_VALUE,
    REG_MASK,
    REG_PEND,
    REG_CTRL,
    REG_NONE
  } reg_sel_e;

  // Anything that is not an exact register offset selects nothing.
  function automatic reg_sel_e decode_offset(input logic [7:0] off);
    case (off)
      OFF_VALUE: return REG_VALUE;
      OFF_MASK:  return REG_MASK;
      OFF_PEND:  return REG_PEND;
      OFF_CTRL:  return REG_CTRL;
      default:   return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// One switch bit: 2-flop synchronizer, saturating-free debounce counter and
// the debounced stable flop. change is high in the cycle whose closing edge
// updates stable, so a consumer can act on that same edge.
module sw_debounce #(
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable,
  output logic change
);

  localparam int unsigned CW = $clog2(DB_CYCLES + 1);
  // The counter never holds DB_CYCLES: the edge that would reach it instead
  // commits the new value and clears, so the counter cannot wrap.
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          stable_reg;
  logic [CW-1:0] count_reg;
  logic          differ;
  logic          done;

  assign differ = (sync2_reg != stable_reg);
  assign done   = differ && (count_reg == LAST);

  // Bring the asynchronous level into the clock domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
    end
  end

  // Count consecutive mismatching cycles; commit after DB_CYCLES of them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_reg <= 1'b0;
      count_reg  <= '0;
    end else if (done) begin
      stable_reg <= sync2_reg;
      count_reg  <= '0;
    end else if (differ) begin
      count_reg  <= count_reg + 1'b1;
    end else begin
      count_reg  <= '0;
    end
  end

  assign stable = stable_reg;
  assign change = done;

endmodule

// File: rtl/sw_irq_sb_ctrl.sv
// Debounced switch bank with a small register interface: VALUE, MASK,
// PEND (write-one-to-clear, set wins) and CTRL global enable. irq_o is a
// pure function of registers so bus inputs never reach it combinationally.
module sw_irq_sb_ctrl
  import sw_ctrl_pkg::*;
#(
  parameter int unsigned N_SW      = 16,
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [31:0]     addr_i,
  input  logic            req_i,
  input  logic            WE_i,
  input  logic [31:0]     WD_i,
  output logic [31:0]     RD_o,
  input  logic [N_SW-1:0] sw_i,
  output logic            irq_o
);

  logic [N_SW-1:0] stable;
  logic [N_SW-1:0] change;
  logic [N_SW-1:0] mask_reg;
  logic [N_SW-1:0] pend_reg;
  logic [N_SW-1:0] pend_clr;
  logic [N_SW-1:0] pend_next;
  logic            ctrl_reg;
  logic [31:0]     rd_reg;
  logic [31:0]     rd_next;
  reg_sel_e        sel;
  logic            wr_en;
  logic            rd_en;
  logic            unused_bus;

  for (genvar gi = 0; gi < N_SW; gi++) begin : g_db
    sw_debounce #(
      .DB_CYCLES(DB_CYCLES)
    ) u_db (
      .clk    (clk_i),
      .rst    (rst_i),
      .raw    (sw_i[gi]),
      .stable (stable[gi]),
      .change (change[gi])
    );
  end

  assign sel        = decode_offset(addr_i[7:0]);
  assign wr_en      = req_i & WE_i;
  assign rd_en      = req_i & ~WE_i;
  assign unused_bus = ^{addr_i[31:8], WD_i};

  // Pending flags: clear by writing ones, a same-edge change re-sets the bit.
  always_comb begin
    pend_clr = '0;
    if (wr_en && (sel == REG_PEND)) begin
      pend_clr = WD_i[N_SW-1:0];
    end
    pend_next = (pend_reg & ~pend_clr) | change;
  end

  // Read mux; unimplemented bits and undecoded offsets return zero.
  always_comb begin
    rd_next = '0;
    case (sel)
      REG_VALUE: rd_next = 32'(stable);
      REG_MASK:  rd_next = 32'(mask_reg);
      REG_PEND:  rd_next = 32'(pend_reg);
      REG_CTRL:  rd_next = {31'b0, ctrl_reg};
      default:   rd_next = '0;
    endcase
  end

  // Software-visible registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mask_reg <= '0;
      pend_reg <= '0;
      ctrl_reg <= 1'b0;
    end else begin
      pend_reg <= pend_next;
      if (wr_en && (sel == REG_MASK)) mask_reg <= WD_i[N_SW-1:0];
      if (wr_en && (sel == REG_CTRL)) ctrl_reg <= WD_i[0];
    end
  end

  // Read data is captured on a read and held until the next one.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_reg <= '0;
    end else if (rd_en) begin
      rd_reg <= rd_next;
    end
  end

  assign RD_o  = rd_reg;
  assign irq_o = ctrl_reg & (|(pend_reg & mask_reg));

endmodule

// File: tb/tb_sw_irq_sb_ctrl.sv
// Bench for sw_irq_sb_ctrl: register-access vector table, hand sequences for
// debounce latency / glitch / set-wins / async reset, then random traffic
// compared against a history-window reference model.
module tb_sw_irq_sb_ctrl;

  localparam int N  = 16;
  localparam int DB = 4;

  logic          clk  = 1'b0;
  logic          rst  = 1'b0;
  logic [31:0]   addr = '0;
  logic          req  = 1'b0;
  logic          we   = 1'b0;
  logic [31:0]   wd   = '0;
  logic [31:0]   rd;
  logic [N-1:0]  sw   = '0;
  logic          irq;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sw_irq_sb_ctrl #(
    .N_SW      (N),
    .DB_CYCLES (DB)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .addr_i (addr),
    .req_i  (req),
    .WE_i   (we),
    .WD_i   (wd),
    .RD_o   (rd),
    .sw_i   (sw),
    .irq_o  (irq)
  );

  // Reference model: raw samples of the last DB+2 edges; a bit's stable
  // value flips when the synchronized samples (raw delayed by two edges)
  // have disagreed with it for DB consecutive edges.
  logic [N-1:0] hist [DB+2];
  logic [N-1:0] m_value, m_mask, m_pend;
  logic         m_ctrl;
  logic [31:0]  m_rd;
  logic         m_irq;

  task automatic model_reset();
    for (int i = 0; i < DB + 2; i++) hist[i] = '0;
    m_value = '0; m_mask = '0; m_pend = '0;
    m_ctrl = 1'b0; m_rd = '0; m_irq = 1'b0;
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    case (a[7:0])
      8'h00:   return 32'(m_value);
      8'h04:   return 32'(m_mask);
      8'h08:   return 32'(m_pend);
      8'h0C:   return {31'b0, m_ctrl};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_step(input logic [N-1:0] s, input logic r, input logic w,
                            input logic [31:0] a, input logic [31:0] d);
    logic [N-1:0] flips;
    logic         all_diff;
    for (int i = DB + 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = s;
    flips = '0;
    for (int b = 0; b < N; b++) begin
      all_diff = 1'b1;
      for (int i = 2; i <= DB + 1; i++)
        if (hist[i][b] == m_value[b]) all_diff = 1'b0;
      flips[b] = all_diff;
    end
    if (r && !w) m_rd = m_read(a);
    if (r && w) begin
      case (a[7:0])
        8'h04:   m_mask = d[N-1:0];
        8'h08:   m_pend = m_pend & ~d[N-1:0];
        8'h0C:   m_ctrl = d[0];
        default: ;
      endcase
    end
    m_pend  = m_pend | flips;
    m_value = m_value ^ flips;
    m_irq   = m_ctrl && ((m_pend & m_mask) != '0);
  endtask

  // One clock edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic tick();
    logic [N-1:0] s;
    logic         r, w, rs;
    logic [31:0]  a, d;
    s = sw; r = req; w = we; a = addr; d = wd; rs = rst;
    @(posedge clk);
    if (rs) model_reset();
    else    model_step(s, r, w, a, d);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr = a; wd = d; we = 1'b1; req = 1'b1;
    tick();
    req = 1'b0; we = 1'b0;
    $display("wr addr=0x%02h data=0x%08h irq=%0b", a[7:0], d, irq);
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    addr = a; we = 1'b0; req = 1'b1;
    tick();
    d = rd; req = 1'b0;
    $display("rd addr=0x%02h data=0x%08h irq=%0b", a[7:0], d, irq);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[18];

  initial begin
    logic [31:0] d;
    int          idx;

    vecs[0]  = '{1'b0, 32'h00, 32'h0,        32'h0,      1'b0};
    vecs[1]  = '{1'b0, 32'h04, 32'h0,        32'h0,      1'b0};
    vecs[2]  = '{1'b0, 32'h08, 32'h0,        32'h0,      1'b0};
    vecs[3]  = '{1'b0, 32'h0C, 32'h0,        32'h0,      1'b0};
    vecs[4]  = '{1'b1, 32'h04, 32'hFFFFFFFF, 32'h0,      1'b0};
    vecs[5]  = '{1'b0, 32'h04, 32'h0,        32'h0000FFFF, 1'b0};
    vecs[6]  = '{1'b1, 32'h0C, 32'hFFFFFFFF, 32'h0,      1'b0};
    vecs[7]  = '{1'b0, 32'h10, 32'h0,        32'h0,      1'b0};
    vecs[8]  = '{1'b0, 32'h0C, 32'h0,        32'h1,      1'b0};
    vecs[9]  = '{1'b1, 32'h10, 32'h12345678, 32'h0,      1'b0};
    vecs[10] = '{1'b0, 32'h10, 32'h0,        32'h0,      1'b0};
    vecs[11] = '{1'b1, 32'h00, 32'h0000FFFF, 32'h0,      1'b0};
    vecs[12] = '{1'b0, 32'h00, 32'h0,        32'h0,      1'b0};
    vecs[13] = '{1'b0, 32'h05, 32'h0,        32'h0,      1'b0};
    vecs[14] = '{1'b1, 32'h04, 32'h0,        32'h0,      1'b0};
    vecs[15] = '{1'b1, 32'h0C, 32'h0,        32'h0,      1'b0};
    vecs[16] = '{1'b0, 32'h04, 32'h0,        32'h0,      1'b0};
    vecs[17] = '{1'b0, 32'h0C, 32'h0,        32'h0,      1'b0};

    // Reset state
    rst = 1'b1;
    model_reset();
    repeat (2) tick();
    check("reset_rd", rd, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);
    rst = 1'b0;
    tick();

    // Register access table
    for (int i = 0; i < 18; i++) begin
      if (vecs[i].we) begin
        bus_write(vecs[i].addr, vecs[i].wd);
      end else begin
        bus_read(vecs[i].addr, d);
        check($sformatf("vec%0d_rd", i), d, vecs[i].exp_rd);
      end
      check($sformatf("vec%0d_irq", i), {31'b0, irq}, {31'b0, vecs[i].exp_irq});
      if (i == 8) begin
        repeat (2) tick();
        check("rd_hold", rd, 32'h1);
      end
    end

    // Debounce latency: stable changes on edge 2+DB after the input change
    sw = 16'h0001;
    repeat (5) tick();
    bus_read(32'h00, d);
    check("latency_edge6_old", d, 32'h0);
    bus_read(32'h00, d);
    check("latency_value", d, 32'h1);
    bus_read(32'h08, d);
    check("latency_pend", d, 32'h1);
    check("latency_irq", {31'b0, irq}, 32'h0);

    // Interrupt enable and PEND write-one-to-clear
    bus_write(32'h04, 32'h1);
    check("irq_mask_only", {31'b0, irq}, 32'h0);
    bus_write(32'h0C, 32'h1);
    check("irq_set", {31'b0, irq}, 32'h1);
    bus_write(32'h08, 32'h1);
    check("irq_clr", {31'b0, irq}, 32'h0);
    bus_read(32'h08, d);
    check("pend_clr", d, 32'h0);

    // Three-cycle glitch on bit 3 is rejected
    bus_write(32'h04, 32'h9);
    sw = 16'h0009;
    repeat (3) tick();
    sw = 16'h0001;
    repeat (10) tick();
    bus_read(32'h00, d);
    check("glitch_value", d, 32'h1);
    bus_read(32'h08, d);
    check("glitch_pend", d, 32'h0);
    check("glitch_irq", {31'b0, irq}, 32'h0);

    // PEND clear on the same edge bit 3 becomes stable: set wins
    sw = 16'h0009;
    repeat (5) tick();
    bus_write(32'h08, 32'h8);
    bus_read(32'h08, d);
    check("setwins_pend", d, 32'h8);
    check("setwins_irq", {31'b0, irq}, 32'h1);
    bus_read(32'h00, d);
    check("setwins_value", d, 32'h9);

    // Asynchronous reset in the middle of a debounce (counter at 2)
    sw = 16'h0001;
    repeat (4) tick();
    #2 rst = 1'b1;
    model_reset();
    #1;
    check("async_rst_irq", {31'b0, irq}, 32'h0);
    check("async_rst_rd", rd, 32'h0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (5) tick();
    bus_read(32'h00, d);
    check("rst_latency_old", d, 32'h0);
    bus_read(32'h00, d);
    check("rst_latency_value", d, 32'h1);
    bus_read(32'h08, d);
    check("rst_pend", d, 32'h1);
    bus_read(32'h04, d);
    check("rst_mask", d, 32'h0);
    bus_read(32'h0C, d);
    check("rst_ctrl", d, 32'h0);

    // Random traffic against the reference model
    bus_write(32'h04, $urandom());
    bus_write(32'h0C, 32'h1);
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(3) == 0) begin
        idx = $urandom_range(N - 1);
        sw[idx] = ~sw[idx];
      end
      if ($urandom_range(2) == 0) begin
        case ($urandom_range(5))
          0: addr = 32'h00;
          1: addr = 32'h04;
          2: addr = 32'h08;
          3: addr = 32'h0C;
          4: addr = 32'h10;
          default: addr = $urandom();
        endcase
        we  = $urandom_range(1) == 1;
        wd  = $urandom();
        req = 1'b1;
        $display("rnd %s addr=0x%02h data=0x%08h", we ? "wr" : "rd", addr[7:0], wd);
      end
      tick();
      req = 1'b0;
      we  = 1'b0;
      check($sformatf("rnd%0d_rd", c), rd, m_rd);
      check($sformatf("rnd%0d_irq", c), {31'b0, irq}, {31'b0, m_irq});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
